// File: rtl/sha512_msg_feeder.sv
// sha512_msg_feeder
//
// Message-side front end for a SHA-512 core. Collects a big-endian 64-bit word stream into a
// single 1024-bit block buffer, applies SHA-512 padding (0x80 marker, zero fill, 128-bit message
// bit length) and hands each block to the core over its init/next/ready/digest_valid interface.
// The digest of the final block is registered and offered on a valid/ready output.
//
// Ports
//   clk, reset                 clock and asynchronous active-high reset
//   s_valid/s_ready            input word handshake (s_ready only while filling)
//   s_data, s_last, s_nbytes   word (first byte in [63:56]), last marker, valid bytes in last word
//   core_init/core_next        one-cycle start pulses for the first / a subsequent block
//   core_block                 block buffer, word 0 in [1023:960]
//   core_ready                 core idle
//   core_digest(_valid)        core result
//   m_valid/m_ready, m_digest  final digest handshake
module sha512_msg_feeder (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [63:0]   s_data,
  input  logic          s_last,
  input  logic [3:0]    s_nbytes,
  output logic          core_init,
  output logic          core_next,
  output logic [1023:0] core_block,
  input  logic          core_ready,
  input  logic [511:0]  core_digest,
  input  logic          core_digest_valid,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [511:0]  m_digest
);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StPad,
    StIssue,
    StWait,
    StOut
  } state_e;

  localparam logic [63:0] MarkWord = 64'h8000_0000_0000_0000;

  state_e      state;
  logic [63:0] blk [16];     // block buffer, doubles as the core_block register
  logic [3:0]  w_idx;        // next buffer word to write in FILL
  logic [63:0] byte_cnt;     // message length in bytes (wraps)
  logic        first_blk;    // next issue is the first block of the message
  logic        final_blk;    // block in flight is the last one of the message
  logic        len_pending;  // length did not fit, an extra length-only block follows
  logic [4:0]  p_idx;        // word holding the 0x80 marker; 16 = spilled into the next block
  logic        spill;        // marker sits alone in word p_idx (last word was a full 8 bytes)
  logic        wait_armed;   // first WAIT cycle has passed

  logic [3:0]  nb_eff;
  logic [63:0] last_word;
  logic [63:0] len_hi;
  logic [63:0] len_lo;
  logic        fits;

  // Keep bytes below nb, place 0x80 at byte nb, zero the rest. nb=8 leaves the word untouched.
  function automatic logic [63:0] merge_last(input logic [63:0] data, input logic [3:0] nb);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < nb) begin
        w[63-8*k -: 8] = data[63-8*k -: 8];
      end else if (4'(k) == nb) begin
        w[63-8*k -: 8] = 8'h80;
      end
    end
    return w;
  endfunction

  always_comb begin
    nb_eff    = (s_nbytes > 4'd8) ? 4'd8 : s_nbytes;
    last_word = merge_last(s_data, nb_eff);
    // 128-bit length in bits = {61'b0, byte_cnt, 3'b000}
    len_hi    = {61'b0, byte_cnt[63:61]};
    len_lo    = {byte_cnt[60:0], 3'b000};
    fits      = (p_idx <= 5'd13);
  end

  always_comb begin
    core_block = '0;
    for (int i = 0; i < 16; i++) begin
      core_block[1023-64*i -: 64] = blk[i];
    end
  end

  // The pulse lands in the ISSUE cycle that sees core_ready; state is IDLE while in reset.
  assign core_init = (state == StIssue) && core_ready && first_blk;
  assign core_next = (state == StIssue) && core_ready && !first_blk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      w_idx       <= '0;
      byte_cnt    <= '0;
      first_blk   <= 1'b1;
      final_blk   <= 1'b0;
      len_pending <= 1'b0;
      p_idx       <= '0;
      spill       <= 1'b0;
      wait_armed  <= 1'b0;
      s_ready     <= 1'b0;
      m_valid     <= 1'b0;
      m_digest    <= '0;
      for (int i = 0; i < 16; i++) begin
        blk[i] <= '0;
      end
    end else begin
      case (state)
        StIdle: begin
          byte_cnt    <= '0;
          w_idx       <= '0;
          final_blk   <= 1'b0;
          len_pending <= 1'b0;
          first_blk   <= 1'b1;
          for (int i = 0; i < 16; i++) begin
            blk[i] <= '0;
          end
          s_ready     <= 1'b1;
          state       <= StFill;
        end

        StFill: begin
          if (s_valid) begin
            blk[w_idx] <= s_last ? last_word : s_data;
            w_idx      <= w_idx + 4'd1;
            byte_cnt   <= byte_cnt + (s_last ? {60'b0, nb_eff} : 64'd8);
            if (s_last) begin
              // A full last word pushes the marker into the following word (or block).
              p_idx   <= (nb_eff == 4'd8) ? ({1'b0, w_idx} + 5'd1) : {1'b0, w_idx};
              spill   <= (nb_eff == 4'd8);
              s_ready <= 1'b0;
              state   <= StPad;
            end else if (w_idx == 4'd15) begin
              final_blk <= 1'b0;
              s_ready   <= 1'b0;
              state     <= StIssue;
            end
          end
        end

        StPad: begin
          // Whole tail of the block in one cycle: marker word if it stands alone, then zero
          // fill, with the length in words 14-15 when the marker left room for it.
          for (int i = 0; i < 16; i++) begin
            if (spill && (5'(i) == p_idx)) begin
              blk[i] <= MarkWord;
            end else if (5'(i) > p_idx) begin
              if (fits && (i == 14)) begin
                blk[i] <= len_hi;
              end else if (fits && (i == 15)) begin
                blk[i] <= len_lo;
              end else begin
                blk[i] <= '0;
              end
            end
          end
          final_blk   <= fits;
          len_pending <= !fits;
          state       <= StIssue;
        end

        StIssue: begin
          wait_armed <= 1'b0;
          if (core_ready) begin
            first_blk <= 1'b0;
            state     <= StWait;
          end
        end

        StWait: begin
          // digest_valid is stale in the first WAIT cycle; the core clears it on the pulse edge.
          wait_armed <= 1'b1;
          if (wait_armed && core_digest_valid) begin
            if (final_blk) begin
              m_digest <= core_digest;
              m_valid  <= 1'b1;
              state    <= StOut;
            end else if (len_pending) begin
              for (int i = 0; i < 16; i++) begin
                if (i == 14) begin
                  blk[i] <= len_hi;
                end else if (i == 15) begin
                  blk[i] <= len_lo;
                end else if ((i == 0) && (p_idx == 5'd16)) begin
                  blk[i] <= MarkWord;
                end else begin
                  blk[i] <= '0;
                end
              end
              len_pending <= 1'b0;
              final_blk   <= 1'b1;
              state       <= StIssue;
            end else begin
              for (int i = 0; i < 16; i++) begin
                blk[i] <= '0;
              end
              w_idx   <= '0;
              s_ready <= 1'b1;
              state   <= StFill;
            end
          end
        end

        StOut: begin
          if (m_ready) begin
            m_valid     <= 1'b0;
            byte_cnt    <= '0;
            w_idx       <= '0;
            final_blk   <= 1'b0;
            len_pending <= 1'b0;
            state       <= StIdle;
          end
        end

        default: begin
          s_ready <= 1'b0;
          m_valid <= 1'b0;
          state   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha512_msg_feeder.sv
// Bench for sha512_msg_feeder: a stand-in core that records every issued block and answers with
// random digests, and a byte-level SHA-512 padding model that predicts the issued blocks.
module tb_sha512_msg_feeder;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [63:0]   s_data;
  logic          s_last;
  logic [3:0]    s_nbytes;
  logic          core_init;
  logic          core_next;
  logic [1023:0] core_block;
  logic          core_ready;
  logic [511:0]  core_digest;
  logic          core_digest_valid;
  logic          m_valid;
  logic          m_ready;
  logic [511:0]  m_digest;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sha512_msg_feeder dut (
    .clk               (clk),
    .reset             (reset),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .s_last            (s_last),
    .s_nbytes          (s_nbytes),
    .core_init         (core_init),
    .core_next         (core_next),
    .core_block        (core_block),
    .core_ready        (core_ready),
    .core_digest       (core_digest),
    .core_digest_valid (core_digest_valid),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_digest          (m_digest)
  );

  `define CHK(tag, o, e) \
    begin \
      checks++; \
      assert ((o) === (e)) else begin \
        failures++; \
        $error("FAIL %s observed=%0h expected=%0h", tag, (o), (e)); \
      end \
    end

  // ---------------- stand-in core ----------------
  logic [1024:0] issued_q[$];   // {was_init, block} per start pulse
  logic          busy;
  int            lat;
  logic [1023:0] held_blk;
  logic [511:0]  junk_q;
  logic [511:0]  last_dig;
  int            stable_err = 0;

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  assign core_digest = busy ? junk_q : last_dig;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy              <= 1'b0;
      lat               <= 0;
      core_ready        <= 1'b1;
      core_digest_valid <= 1'b0;
      junk_q            <= '0;
      last_dig          <= '0;
      held_blk          <= '0;
    end else if (core_init || core_next) begin
      issued_q.push_back({core_init, core_block});
      busy              <= 1'b1;
      lat               <= int'($urandom_range(2, 6));
      core_ready        <= 1'b0;
      core_digest_valid <= 1'b0;
      held_blk          <= core_block;
      junk_q            <= rand512();
    end else if (busy) begin
      if (core_block !== held_blk) stable_err <= stable_err + 1;
      junk_q <= rand512();
      if (lat == 0) begin
        busy              <= 1'b0;
        core_ready        <= 1'b1;
        core_digest_valid <= 1'b1;
        last_dig          <= rand512();
      end else begin
        lat <= lat - 1;
      end
    end
  end

  function automatic logic [63:0] iss_word(input int b, input int j);
    logic [1024:0] r;
    if (b >= issued_q.size()) return 'x;
    r = issued_q[b];
    return r[1023-64*j -: 64];
  endfunction

  function automatic logic iss_init(input int b);
    logic [1024:0] r;
    if (b >= issued_q.size()) return 1'bx;
    r = issued_q[b];
    return r[1024];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_word(input logic [63:0] w, input logic last, input logic [3:0] nb);
    int n;
    repeat ($urandom_range(0, 2)) begin
      s_valid = 1'b0;
      s_data  = {$urandom, $urandom};
      @(negedge clk);
    end
    s_valid  = 1'b1;
    s_data   = w;
    s_last   = last;
    s_nbytes = nb;
    n = 0;
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    `CHK("s_ready_wait", s_ready, 1'b1)
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_msg(input int nfull, input int nb, input logic [63:0] last_data,
                         input bit given, input int hold);
    logic [7:0]   msg[$];
    logic [7:0]   pad[$];
    logic [63:0]  w;
    logic [63:0]  ew;
    logic [127:0] lbits;
    int           n;
    int           nblk;
    issued_q.delete();
    for (int i = 0; i < nfull; i++) begin
      w = {$urandom, $urandom};
      send_word(w, 1'b0, 4'd0);
      for (int k = 0; k < 8; k++) msg.push_back(w[63-8*k -: 8]);
    end
    w = given ? last_data : {$urandom, $urandom};
    send_word(w, 1'b1, 4'(nb));
    for (int k = 0; k < nb; k++) msg.push_back(w[63-8*k -: 8]);

    n = 0;
    while (!m_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    `CHK("m_valid_rise", m_valid, 1'b1)

    // Reference padding: message, 0x80, zeros to 112 mod 128, 128-bit big-endian bit length.
    pad = msg;
    pad.push_back(8'h80);
    while (pad.size() % 128 != 112) pad.push_back(8'h00);
    lbits = 128'(msg.size()) << 3;
    for (int k = 0; k < 16; k++) pad.push_back(lbits[127-8*k -: 8]);
    nblk = pad.size() / 128;

    `CHK("block_count", issued_q.size(), nblk)
    for (int b = 0; b < nblk; b++) begin
      `CHK($sformatf("blk%0d_init_flag", b), iss_init(b), (b == 0))
      for (int j = 0; j < 16; j++) begin
        ew = '0;
        for (int k = 0; k < 8; k++) ew = {ew[55:0], pad[b*128 + 8*j + k]};
        `CHK($sformatf("blk%0d_word%0d", b, j), iss_word(b, j), ew)
      end
    end
    `CHK("m_digest", m_digest, last_dig)

    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      `CHK("hold_m_valid", m_valid, 1'b1)
      `CHK("hold_m_digest", m_digest, last_dig)
      `CHK("hold_s_ready", s_ready, 1'b0)
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    `CHK("m_valid_after_accept", m_valid, 1'b0)
  endtask

  // ---------------- sequence ----------------
  initial begin
    int n;
    reset    = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    s_nbytes = '0;
    m_ready  = 1'b0;
    repeat (3) @(negedge clk);
    `CHK("rst_s_ready", s_ready, 1'b0)
    `CHK("rst_core_init", core_init, 1'b0)
    `CHK("rst_core_next", core_next, 1'b0)
    `CHK("rst_core_block_zero", (core_block == '0), 1'b1)
    `CHK("rst_m_valid", m_valid, 1'b0)
    `CHK("rst_m_digest", m_digest, 512'h0)

    reset = 1'b0;
    #1;
    `CHK("rel_s_ready_low", s_ready, 1'b0)
    @(posedge clk);
    @(posedge clk);
    #1;
    `CHK("rel_s_ready_2nd_edge", s_ready, 1'b1)
    @(negedge clk);

    // "abc" with a long output stall
    run_msg(0, 3, 64'h6162_6300_0000_0000, 1'b1, 10);
    `CHK("abc_word0", iss_word(0, 0), 64'h6162_6380_0000_0000)
    `CHK("abc_word15", iss_word(0, 15), 64'h18)
    // empty message
    run_msg(0, 0, 64'h0, 1'b0, 1);
    `CHK("empty_word0", iss_word(0, 0), 64'h8000_0000_0000_0000)
    `CHK("empty_word15", iss_word(0, 15), 64'h0)
    // 112 bytes: marker in word 14, length needs a second block
    run_msg(13, 8, 64'h0, 1'b0, 0);
    `CHK("b112_blk0_word14", iss_word(0, 14), 64'h8000_0000_0000_0000)
    `CHK("b112_blk1_word15", iss_word(1, 15), 64'h380)
    // 128 bytes: marker spills into the next block
    run_msg(15, 8, 64'h0, 1'b0, 0);
    `CHK("b128_blk1_word0", iss_word(1, 0), 64'h8000_0000_0000_0000)
    `CHK("b128_blk1_word15", iss_word(1, 15), 64'h400)
    // 111 bytes: single block
    run_msg(13, 7, 64'h0, 1'b0, 0);
    `CHK("b111_word13_lsb", iss_word(0, 13) & 64'hff, 64'h80)
    `CHK("b111_word15", iss_word(0, 15), 64'h378)
    // zero-byte last word right at word 15
    run_msg(15, 0, 64'h0, 1'b0, 0);

    for (int r = 0; r < 8; r++) begin
      run_msg(int'($urandom_range(0, 40)), int'($urandom_range(0, 8)), 64'h0, 1'b0,
              int'($urandom_range(0, 3)));
    end

    // Reset while the core is busy with a block
    issued_q.delete();
    for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, 1'b0, 4'd0);
    send_word({$urandom, $urandom}, 1'b1, 4'd5);
    n = 0;
    while (issued_q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    `CHK("wait_issue_seen", (issued_q.size() > 0), 1'b1)
    reset = 1'b1;
    #1;
    `CHK("wrst_s_ready", s_ready, 1'b0)
    `CHK("wrst_core_init", core_init, 1'b0)
    `CHK("wrst_core_next", core_next, 1'b0)
    `CHK("wrst_core_block_zero", (core_block == '0), 1'b1)
    `CHK("wrst_m_valid", m_valid, 1'b0)
    `CHK("wrst_m_digest", m_digest, 512'h0)
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    `CHK("wrel_s_ready_low", s_ready, 1'b0)
    @(posedge clk);
    @(posedge clk);
    #1;
    `CHK("wrel_s_ready_2nd_edge", s_ready, 1'b1)
    @(negedge clk);
    run_msg(int'($urandom_range(0, 20)), int'($urandom_range(0, 8)), 64'h0, 1'b0, 2);

    `CHK("block_stable_while_busy", stable_err, 0)

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
